// File: rtl/cacheline_adapter_if.sv
// Bundle between cache control (pmem_*) and the 64-bit burst memory bus.
// slave: adapter view; master: cache/memory side view.
interface cacheline_adapter_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         pmem_error;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  burst_rdata, burst_resp,
    output pmem_rdata, pmem_resp, pmem_error,
    output burst_read, burst_write, burst_address, burst_wdata
  );

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    output burst_rdata, burst_resp,
    input  pmem_rdata, pmem_resp, pmem_error,
    input  burst_read, burst_write, burst_address, burst_wdata
  );
endinterface

// File: rtl/cacheline_adapter.sv
// 256-bit cache line <-> 4x64-bit burst adapter; ports clk, rst_n, bus.
// Optional per-beat watchdog: define CACHELINE_ADAPTER_WATCHDOG_EN.
module cacheline_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  cacheline_adapter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, RD, WR, DONE
  } state_t;

  state_t       st_q, st_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [255:0] line_q, line_d;
  logic [255:0] rdata_d;
  logic [31:0]  addr_d;
  logic [63:0]  wdata_d;
  logic         rd_d, wr_d, resp_d, err_d;
  logic         accept, busy, beat, last, tmo;

  assign busy = (st_q == RD) || (st_q == WR);
  assign beat = busy && bus.burst_resp;
  assign last = beat && (cnt_q == 2'd3);

`ifdef CACHELINE_ADAPTER_WATCHDOG_EN
  logic [7:0] wdog_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (accept || beat) begin
      wdog_q <= '0;
    end else if (busy) begin
      wdog_q <= wdog_q + 8'd1;
    end
  end

  // Fires on the idle cycle that would bring the count to the limit.
  assign tmo = busy && !bus.burst_resp &&
               (wdog_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q              <= IDLE;
      cnt_q             <= '0;
      line_q            <= '0;
      bus.pmem_rdata    <= '0;
      bus.pmem_resp     <= 1'b0;
      bus.pmem_error    <= 1'b0;
      bus.burst_read    <= 1'b0;
      bus.burst_write   <= 1'b0;
      bus.burst_address <= '0;
      bus.burst_wdata   <= '0;
    end else begin
      st_q              <= st_d;
      cnt_q             <= cnt_d;
      line_q            <= line_d;
      bus.pmem_rdata    <= rdata_d;
      bus.pmem_resp     <= resp_d;
      bus.pmem_error    <= err_d;
      bus.burst_read    <= rd_d;
      bus.burst_write   <= wr_d;
      bus.burst_address <= addr_d;
      bus.burst_wdata   <= wdata_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: begin
        if (bus.pmem_write) begin
          st_d = WR;
        end else if (bus.pmem_read) begin
          st_d = RD;
        end
      end
      RD, WR: begin
        if (last || tmo) begin
          st_d = DONE;
        end
      end
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    accept = (st_q == IDLE) &&
             (bus.pmem_read || bus.pmem_write);
    line_d = accept ? bus.pmem_wdata : line_q;
    addr_d = accept ? {bus.pmem_address[31:5], 5'b0}
                    : bus.burst_address;
    cnt_d  = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (beat) begin
      cnt_d = cnt_q + 2'd1;
    end
    rdata_d = bus.pmem_rdata;
    if (st_q == RD && bus.burst_resp) begin
      rdata_d[{cnt_q, 6'd0} +: 64] = bus.burst_rdata;
    end
    rd_d    = (st_d == RD);
    wr_d    = (st_d == WR);
    // Registered, so present the slice for the beat count after this edge.
    wdata_d = wr_d ? line_d[{cnt_d, 6'd0} +: 64] : '0;
    resp_d  = (st_d == DONE);
    err_d   = tmo;
  end
endmodule

// File: tb/tb_cacheline_adapter.sv
// Randomized bench for cacheline_adapter against a transaction-level model.
// Watchdog checks follow CACHELINE_ADAPTER_WATCHDOG_EN.
module tb_cacheline_adapter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchk = 0;
  int   nerr = 0;
  logic [255:0] exp_rd = '0;

  always #5 clk = ~clk;

  cacheline_adapter_if bus ();

  cacheline_adapter #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      v = {v[223:0], 32'($urandom)};
    end
    return v;
  endfunction

  // stall < 0: random 0..3 wait cycles before every beat;
  // stall >= 0: that many wait cycles between beats.
  task automatic txn(input bit wr, input bit both, input bit hold,
                     input logic [31:0] addr,
                     input logic [255:0] wline,
                     input logic [255:0] rline,
                     input int stall);
    int cyc, nst, st;
    logic [31:0] exp_a;
    logic [63:0] sl;
    @(negedge clk);
    bus.pmem_write   = wr;
    bus.pmem_read    = !wr || both;
    bus.pmem_address = addr;
    bus.pmem_wdata   = wline;
    @(negedge clk);
    if (!hold) begin
      bus.pmem_read  = 1'b0;
      bus.pmem_write = 1'b0;
    end
    exp_a = {addr[31:5], 5'b0};
    cyc = 1;
    nst = 0;
    chk("addr", 256'(bus.burst_address), 256'(exp_a));
    for (int b = 0; b < 4; b++) begin
      if (stall >= 0) st = (b == 0) ? 0 : stall;
      else st = int'($urandom_range(0, 3));
      nst += st;
      for (int s = 0; s <= st; s++) begin
        sl = rline[64*b +: 64];
        bus.burst_resp  = (s == st);
        bus.burst_rdata = (s == st) ? sl : 64'($urandom);
        chk("strobe_rd", 256'(bus.burst_read), 256'(!wr));
        chk("strobe_wr", 256'(bus.burst_write), 256'(wr));
        if (wr) begin
          sl = wline[64*b +: 64];
          chk("wdata", 256'(bus.burst_wdata), 256'(sl));
        end
        chk("resp_busy", 256'(bus.pmem_resp), 256'(0));
        chk("addr_hold", 256'(bus.burst_address), 256'(exp_a));
        @(negedge clk);
        cyc++;
      end
    end
    bus.burst_resp = 1'b0;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    chk("latency", 256'(cyc), 256'(5 + nst));
    chk("resp", 256'(bus.pmem_resp), 256'(1));
    chk("error", 256'(bus.pmem_error), 256'(0));
    chk("strobes_off",
        256'({bus.burst_read, bus.burst_write}), 256'(0));
    if (!wr) exp_rd = rline;
    chk("rdata", bus.pmem_rdata, exp_rd);
    // Stray burst_resp while idle must do nothing.
    bus.burst_resp  = $urandom_range(0, 1) == 1;
    bus.burst_rdata = 64'($urandom);
    @(negedge clk);
    bus.burst_resp = 1'b0;
    chk("resp_once", 256'(bus.pmem_resp), 256'(0));
    @(negedge clk);
    chk("idle_quiet",
        256'({bus.pmem_resp, bus.burst_read, bus.burst_write}),
        256'(0));
    chk("rdata_hold", bus.pmem_rdata, exp_rd);
  endtask

  initial begin
    logic [255:0] l34, l35;
    int cyc, npulse;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    bus.burst_rdata  = '0;
    bus.burst_resp   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", bus.pmem_rdata, '0);
    chk("rst_outs",
        256'({bus.pmem_resp, bus.pmem_error,
              bus.burst_read, bus.burst_write}), 256'(0));
    chk("rst_addr", 256'(bus.burst_address), 256'(0));
    chk("rst_wdata", 256'(bus.burst_wdata), 256'(0));
    rst_n = 1'b1;

    l34 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    txn(1'b0, 1'b0, 1'b0, 32'h0000_1234, rnd_line(), l34, 0);
    l35 = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    txn(1'b1, 1'b0, 1'b0, 32'h8000_00E0, l35, rnd_line(), 3);
    txn(1'b1, 1'b1, 1'b0, 32'($urandom), rnd_line(), rnd_line(), -1);
    txn(1'b0, 1'b0, 1'b1, 32'($urandom), rnd_line(), rnd_line(), -1);

    for (int n = 0; n < 40; n++) begin
      txn(1'($urandom), 1'($urandom), 1'($urandom),
          32'($urandom), rnd_line(), rnd_line(), -1);
    end

    // Reset in the middle of beat 2 of a read.
    @(negedge clk);
    bus.pmem_read    = 1'b1;
    bus.pmem_address = 32'($urandom);
    @(negedge clk);
    bus.pmem_read = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = 64'($urandom);
      @(negedge clk);
    end
    bus.burst_resp = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes",
        256'({bus.burst_read, bus.burst_write}), 256'(0));
    chk("mid_rst_rdata", bus.pmem_rdata, '0);
    chk("mid_rst_resp", 256'(bus.pmem_resp), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_rd = '0;
    npulse = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.pmem_resp) npulse++;
    end
    chk("mid_rst_no_resp", 256'(npulse), 256'(0));
    txn(1'b0, 1'b0, 1'b0, 32'($urandom), rnd_line(), rnd_line(), -1);

    // No burst_resp ever arrives.
    @(negedge clk);
    bus.pmem_read    = 1'b1;
    bus.pmem_address = 32'($urandom);
    @(negedge clk);
    bus.pmem_read = 1'b0;
`ifdef CACHELINE_ADAPTER_WATCHDOG_EN
    cyc = 0;
    while (bus.burst_read && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    chk("wd_cycles", 256'(cyc), 256'(8));
    chk("wd_resp", 256'(bus.pmem_resp), 256'(1));
    chk("wd_error", 256'(bus.pmem_error), 256'(1));
    chk("wd_rdata", bus.pmem_rdata, exp_rd);
    @(negedge clk);
    chk("wd_resp_once", 256'(bus.pmem_resp), 256'(0));
`else
    cyc = 0;
    npulse = 0;
    repeat (1000) begin
      if (bus.pmem_resp) npulse++;
      if (bus.burst_read) cyc++;
      @(negedge clk);
    end
    chk("nowd_no_resp", 256'(npulse), 256'(0));
    chk("nowd_waiting", 256'(cyc), 256'(1000));
    chk("nowd_error", 256'(bus.pmem_error), 256'(0));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_rd = '0;
`endif
    txn(1'b1, 1'b0, 1'b0, 32'($urandom), rnd_line(), rnd_line(), -1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
